// File: rtl/sw_reg_pkg.sv
// -----------------------------------------------------------------------------
// sw_reg_pkg
// Shared definitions for the software register bank: the Wishbone response
// codes, the register word stride, the register count limit and a byte-lane
// merge helper.
// -----------------------------------------------------------------------------
package sw_reg_pkg;

    typedef enum logic [1:0] {
        WB_RESP_NONE = 2'b00,
        WB_RESP_ACK  = 2'b01,
        WB_RESP_ERR  = 2'b10
    } wb_resp_e;

    localparam int unsigned REG_STRIDE_BYTES = 4;
    localparam int unsigned REG_STRIDE_SHIFT = 2;
    localparam int unsigned MAX_NUM_REGS     = 16;
    // Wide enough to hold MAX_NUM_REGS itself (the commit slot in staged mode).
    localparam int unsigned IDX_W            = 5;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sw_reg_wb_if.sv
// -----------------------------------------------------------------------------
// sw_reg_wb_if
// Wishbone slave front end: qualifies requests, decodes the word index,
// range-checks it and generates the single-cycle ack / err response.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i          Wishbone cycle / strobe
//   wb_adr_i                    byte address
//   wb_ack_o, wb_err_o          registered response (never both high)
//   req_hit                     valid request to an existing register or commit slot
//   req_idx                     decoded word index of the current request
// -----------------------------------------------------------------------------
module sw_reg_wb_if
    import sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR = 32'h0000_FFFF,
    parameter int          NUM_REGS   = 4,
    parameter int          SHADOW     = 0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic [31:0]      wb_adr_i,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             req_hit,
    output logic [IDX_W-1:0] req_idx
);

    // Staged mode exposes one extra word past the registers: the commit slot.
    localparam logic [31:0] IDX_LIMIT = 32'(NUM_REGS) + ((SHADOW != 0) ? 32'd1 : 32'd0);

    wb_resp_e    resp_q;
    logic        req_valid;
    logic        in_window;
    logic        in_range;
    logic [31:0] offset;
    logic [31:0] word_idx;

    // A pending response blocks the next request, so a held strobe is
    // answered on alternate cycles.
    assign req_valid = wb_cyc_i & wb_stb_i & (resp_q == WB_RESP_NONE);
    assign in_window = (wb_adr_i >= C_BASEADDR) && (wb_adr_i <= C_HIGHADDR);
    assign offset    = wb_adr_i - C_BASEADDR;
    assign word_idx  = offset >> REG_STRIDE_SHIFT;
    // Range check on the full index so high addresses never alias onto a register.
    assign in_range  = in_window && (word_idx < IDX_LIMIT);
    assign req_hit   = req_valid & in_range;
    assign req_idx   = word_idx[IDX_W-1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            resp_q <= WB_RESP_NONE;
        end else if (req_valid) begin
            resp_q <= in_range ? WB_RESP_ACK : WB_RESP_ERR;
        end else begin
            resp_q <= WB_RESP_NONE;
        end
    end

    assign wb_ack_o = (resp_q == WB_RESP_ACK);
    assign wb_err_o = (resp_q == WB_RESP_ERR);

endmodule

// File: rtl/sw_reg_bank.sv
// -----------------------------------------------------------------------------
// sw_reg_bank
// Wishbone-mapped bank of NUM_REGS 32-bit software registers driving fabric
// logic. With SHADOW=0 writes land directly in the active registers; with
// SHADOW=1 writes are staged in shadow registers and copied to the active set
// all at once by writing 1 to the commit word at index NUM_REGS.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i   Wishbone cycle / strobe / write enable
//   wb_sel_i                      byte lane select
//   wb_adr_i, wb_dat_i            byte address, write data
//   wb_dat_o                      registered read data, zero outside read acks
//   wb_ack_o, wb_err_o            transfer acknowledge / error
//   fabric_data_out               active register values, reg i at [32i+31:32i]
//   fabric_wr_stb                 one-cycle pulse per active register update
// -----------------------------------------------------------------------------
module sw_reg_bank
    import sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR = 32'h0000_FFFF,
    parameter int          NUM_REGS   = 4,
    parameter int          SHADOW     = 0,
    parameter logic [31:0] RESET_VAL  = 32'h0000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [3:0]              wb_sel_i,
    input  logic [31:0]             wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [32*NUM_REGS-1:0]  fabric_data_out,
    output logic [NUM_REGS-1:0]     fabric_wr_stb
);

    logic [NUM_REGS-1:0][31:0] active_q;
    logic [NUM_REGS-1:0][31:0] shadow_q;
    logic                      req_hit;
    logic [IDX_W-1:0]          req_idx;
    logic                      commit_req;

    sw_reg_wb_if #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR),
        .NUM_REGS   (NUM_REGS),
        .SHADOW     (SHADOW)
    ) u_wb_if (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_adr_i   (wb_adr_i),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .req_hit    (req_hit),
        .req_idx    (req_idx)
    );

    // Only a set bit 0 on an enabled lane 0 triggers the copy.
    assign commit_req = (SHADOW != 0) && (req_idx == IDX_W'(NUM_REGS))
                        && wb_dat_i[0] && wb_sel_i[0];

    // State changes on the same edge that samples the request, so the new
    // value and its strobe are both visible in the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= RESET_VAL;
                shadow_q[i] <= RESET_VAL;
            end
            wb_dat_o      <= '0;
            fabric_wr_stb <= '0;
        end else begin
            wb_dat_o      <= '0;
            fabric_wr_stb <= '0;
            if (req_hit) begin
                if (wb_we_i) begin
                    if (commit_req) begin
                        active_q      <= shadow_q;
                        fabric_wr_stb <= '1;
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if ((req_idx == IDX_W'(i)) && (wb_sel_i != 4'b0000)) begin
                                if (SHADOW != 0) begin
                                    shadow_q[i] <= merge_lanes(shadow_q[i], wb_dat_i, wb_sel_i);
                                end else begin
                                    active_q[i]      <= merge_lanes(active_q[i], wb_dat_i, wb_sel_i);
                                    fabric_wr_stb[i] <= 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    // The commit slot matches no register and reads back as 0.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (req_idx == IDX_W'(i)) begin
                            wb_dat_o <= (SHADOW != 0) ? shadow_q[i] : active_q[i];
                        end
                    end
                end
            end
        end
    end

    assign fabric_data_out = active_q;

endmodule

// File: tb/tb_sw_reg_bank.sv
module tb_sw_reg_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc0, cyc1, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat;

    logic [31:0]  dat0, dat1;
    logic         ack0, ack1, err0, err1;
    logic [127:0] fd0, fd1;
    logic [3:0]   fs0, fs1;

    int tests = 0;
    int fails = 0;

    // Reference state: [dut][reg]; dut 0 is immediate, dut 1 is staged.
    logic [31:0] m_act [2][4];
    logic [31:0] m_sh  [2][4];

    always #5 clk = ~clk;

    sw_reg_bank #(
        .C_BASEADDR (32'h0), .C_HIGHADDR (32'hFFFF), .NUM_REGS (4),
        .SHADOW (0), .RESET_VAL (32'h0)
    ) dut0 (
        .wb_clk_i (clk), .wb_rst_i (rst), .wb_cyc_i (cyc0), .wb_stb_i (stb),
        .wb_we_i (we), .wb_sel_i (sel), .wb_adr_i (adr), .wb_dat_i (wdat),
        .wb_dat_o (dat0), .wb_ack_o (ack0), .wb_err_o (err0),
        .fabric_data_out (fd0), .fabric_wr_stb (fs0)
    );

    sw_reg_bank #(
        .C_BASEADDR (32'h0), .C_HIGHADDR (32'hFFFF), .NUM_REGS (4),
        .SHADOW (1), .RESET_VAL (32'h0)
    ) dut1 (
        .wb_clk_i (clk), .wb_rst_i (rst), .wb_cyc_i (cyc1), .wb_stb_i (stb),
        .wb_we_i (we), .wb_sel_i (sel), .wb_adr_i (adr), .wb_dat_i (wdat),
        .wb_dat_o (dat1), .wb_ack_o (ack1), .wb_err_o (err1),
        .fabric_data_out (fd1), .fabric_wr_stb (fs1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                m_act[d][k] = 32'h0;
                m_sh[d][k]  = 32'h0;
            end
    endtask

    function automatic logic [127:0] exp_fd(input int d);
        return {m_act[d][3], m_act[d][2], m_act[d][1], m_act[d][0]};
    endfunction

    function automatic logic [31:0] lane_write(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    // One complete transfer, starting and ending on a falling edge.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] dv,
                        input logic [3:0] s, input string tag);
        int          idx;
        bit          hit;
        logic [31:0] exp_dat;
        logic [3:0]  exp_stb;
        idx     = int'(a >> 2);
        hit     = (a <= 32'hFFFF) && ((idx < 4) || (d == 1 && idx == 4));
        exp_dat = 32'h0;
        exp_stb = 4'h0;
        if (hit && !w && idx < 4)
            exp_dat = (d == 1) ? m_sh[d][idx] : m_act[d][idx];
        if (hit && w) begin
            if (idx < 4) begin
                if (s != 4'h0) begin
                    if (d == 0) begin
                        m_act[0][idx] = lane_write(m_act[0][idx], dv, s);
                        exp_stb[idx]  = 1'b1;
                    end else begin
                        m_sh[1][idx] = lane_write(m_sh[1][idx], dv, s);
                    end
                end
            end else if (dv[0] && s[0]) begin
                for (int k = 0; k < 4; k++) m_act[1][k] = m_sh[1][k];
                exp_stb = 4'hF;
            end
        end
        @(negedge clk);
        adr = a; wdat = dv; sel = s; we = w; stb = 1'b1;
        cyc0 = (d == 0); cyc1 = (d == 1);
        @(negedge clk);
        chk({tag, "_ack"}, (d == 0) ? ack0 : ack1, hit);
        chk({tag, "_err"}, (d == 0) ? err0 : err1, !hit);
        chk({tag, "_dat"}, (d == 0) ? dat0 : dat1, exp_dat);
        chk({tag, "_stb"}, (d == 0) ? fs0 : fs1, exp_stb);
        chk({tag, "_fab"}, (d == 0) ? fd0 : fd1, exp_fd(d));
        stb = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, (d == 0) ? {ack0, err0, dat0, fs0} : {ack1, err1, dat1, fs1}, 38'h0);
    endtask

    initial begin
        int acks;
        rst = 1'b1; cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out0", {ack0, err0, dat0, fs0, fd0}, 166'h0);
        chk("rst_out1", {ack1, err1, dat1, fs1, fd1}, 166'h0);
        rst = 1'b0;
        @(negedge clk);

        // Immediate mode: full write, lane-masked write, readback.
        xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, "wr_full");
        chk("fab_deadbeef", fd0[63:32], 32'hDEADBEEF);
        xfer(0, 1, 32'h4, 32'h11223344, 4'b0101, "wr_lanes");
        xfer(0, 0, 32'h4, 32'h0, 4'hF, "rd_lanes");
        chk("fab_de22be44", fd0[63:32], 32'hDE22BE44);
        xfer(0, 1, 32'h10, 32'hCAFEF00D, 4'hF, "wr_oob");
        xfer(0, 0, 32'h10, 32'h0, 4'hF, "rd_oob");
        xfer(0, 1, 32'h8, 32'h12345678, 4'h0, "wr_sel0");
        xfer(0, 1, 32'hC, 32'h87654321, 4'hF, "wr_top");
        xfer(0, 1, 32'h10000, 32'h1, 4'hF, "wr_window");

        // Staged mode: write lands in shadow only, commit copies everything.
        xfer(1, 1, 32'h0, 32'hA5A5A5A5, 4'hF, "sh_wr");
        chk("sh_fab_hold", fd1[31:0], 32'h0);
        xfer(1, 0, 32'h0, 32'h0, 4'hF, "sh_rd");
        xfer(1, 1, 32'h10, 32'h0, 4'hF, "sh_commit0");
        xfer(1, 0, 32'h10, 32'h0, 4'hF, "sh_rd_commit");
        xfer(1, 1, 32'h10, 32'h1, 4'hF, "sh_commit1");
        chk("sh_fab_a5", fd1[31:0], 32'hA5A5A5A5);
        xfer(1, 1, 32'h14, 32'h1, 4'hF, "sh_oob");

        // Held strobe: answered on alternate cycles only.
        @(negedge clk);
        adr = 32'h0; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc0 = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("hold_ack%0d", c), ack0, (c % 2 == 0));
            chk($sformatf("hold_dat%0d", c), dat0, (c % 2 == 0) ? m_act[0][0] : 32'h0);
            chk($sformatf("hold_err%0d", c), err0, 1'b0);
            if (ack0) acks++;
        end
        stb = 1'b0; cyc0 = 1'b0;
        chk("hold_count", acks, 3);

        // Reset arriving with a write in flight drops the write entirely.
        @(negedge clk);
        adr = 32'h0; wdat = 32'h12345678; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc0 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_ack", {ack0, err0, fs0}, 6'h0);
        rst = 1'b0; stb = 1'b0; cyc0 = 1'b0; we = 1'b0;
        model_reset();
        chk("rst_drop_fab", fd0, 128'h0);
        chk("rst_drop_fab1", fd1, 128'h0);
        xfer(0, 1, 32'h0, 32'h0BADC0DE, 4'hF, "post_rst_wr");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            int          d, r;
            logic [31:0] a;
            logic [3:0]  s;
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r <= 5)      a = 32'(r * 4);
            else if (r == 6) a = 32'($urandom_range(0, 23));
            else if (r == 7) a = 32'h10000 + 32'($urandom_range(0, 15));
            else             a = 32'((r % 4) * 4);
            s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            xfer(d, bit'($urandom_range(0, 1)), a, $urandom, s, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sw_reg_bank.md
SW_REG_BANK -- requirements
Module: sw_reg_bank

Interface
REQ-001 C_BASEADDR, 32'h00000000, byte base address of the register window SHALL be a parameter.
REQ-002 C_HIGHADDR, 32'h0000FFFF, byte top address of the register window SHALL be a parameter.
REQ-003 NUM_REGS, 4, number of 32-bit registers SHALL be a parameter, legal range 1..16.
REQ-004 SHADOW, 0, update mode SHALL be a parameter: 0 = immediate, 1 = staged until commit.
REQ-005 RESET_VAL, 32'h00000000, reset value of every register SHALL be a parameter.
REQ-006 wb_clk_i  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-007 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-008 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write enable.
REQ-009 wb_sel_i  in  4  byte lane select.
REQ-010 wb_adr_i  in  32  byte address.
REQ-011 wb_dat_i  in  32  write data.
REQ-012 wb_dat_o  out  32  read data, registered.
REQ-013 wb_ack_o  out  1  transfer acknowledge.
REQ-014 wb_err_o  out  1  transfer error.
REQ-015 fabric_data_out  out  32*NUM_REGS  active register values; register i at bits [32i+31:32i].
REQ-016 fabric_wr_stb  out  NUM_REGS  one-cycle pulse per register when its active value is updated.

Function
REQ-017 Request SHALL be valid when wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o; word index = (wb_adr_i - C_BASEADDR) >> 2.
REQ-018 Valid request with index < NUM_REGS (or index == NUM_REGS when SHADOW=1) SHALL assert wb_ack_o for exactly one cycle, in the cycle after the request is sampled.
REQ-019 Valid request with any other index SHALL assert wb_err_o for one cycle with the same latency, change no state, and drive wb_dat_o to 0.
REQ-020 ack and err SHALL never be asserted together; a held strobe SHALL produce a new response every second cycle.
REQ-021 Write SHALL update only byte lanes with wb_sel_i set; wb_sel_i = 0 SHALL still ack but change nothing and raise no strobe.
REQ-022 SHADOW=0: write SHALL update the active register at the ack edge; fabric_wr_stb[i] SHALL pulse in the ack cycle.
REQ-023 SHADOW=1: write SHALL update only the shadow register; active values unchanged.
REQ-024 SHADOW=1: write to index NUM_REGS with wb_dat_i[0]=1 and wb_sel_i[0]=1 SHALL copy all shadow to active in one edge and pulse all fabric_wr_stb bits in the ack cycle; wb_dat_i[0]=0 SHALL ack with no effect.
REQ-025 Read SHALL return the shadow value (SHADOW=1) or active value (SHADOW=0) of the indexed register, registered, valid in the ack cycle; commit register SHALL read 0.
REQ-026 wb_dat_o SHALL be 0 in all cycles without a read ack.
REQ-027 fabric_wr_stb SHALL be 0 in every cycle other than those in REQ-022/REQ-024.

Reset
REQ-028 While wb_rst_i is high at a clock edge, all active and shadow registers SHALL load RESET_VAL; wb_ack_o, wb_err_o, wb_dat_o, fabric_wr_stb SHALL be 0.
REQ-029 A request in progress when reset asserts SHALL be dropped with no response and no state change; first request after reset deasserts SHALL be serviced normally.

Structure
REQ-030 Wishbone response codes, register word stride, and max NUM_REGS SHALL live in shared package sw_reg_pkg.
REQ-031 One sub-module sw_reg_wb_if SHALL implement request decode, ack/err generation and index range check; the register array stays in sw_reg_bank.

Verification
REQ-032 SHADOW=0, write 32'hDEADBEEF sel 4'hF to adr 32'h4 -> ack one cycle later, fabric_data_out[63:32]=32'hDEADBEEF, fabric_wr_stb=4'b0010 for one cycle.
REQ-033 After REQ-032, write 32'h11223344 sel 4'b0101 to adr 32'h4 -> register = 32'hDE22BE44; read adr 32'h4 returns 32'hDE22BE44 with ack.
REQ-034 NUM_REGS=4, write to adr 32'h10 (SHADOW=0) -> wb_err_o one cycle, no ack, fabric_data_out and strobes unchanged.
REQ-035 SHADOW=1, write 32'hA5A5A5A5 to adr 32'h0 -> fabric_data_out[31:0] stays RESET_VAL, read returns 32'hA5A5A5A5; write 32'h1 to adr 32'h10 -> fabric_data_out[31:0]=32'hA5A5A5A5, fabric_wr_stb=4'hF one cycle.
REQ-036 Strobe held high for 6 cycles on adr 32'h0 -> exactly 3 ack pulses, alternating cycles.
REQ-037 Assert wb_rst_i in the cycle a write is sampled -> no ack, register remains RESET_VAL, next write after reset acks normally.
